// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
// master drives operands and out_ready; slave is the adder.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined a+b+c_in, one carry-chained chunk per stage.
// Valid/ready handshake with per-stage bubble collapse.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH ||
        WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipe_adder: invalid WIDTH/STAGES");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO  = (k + 1) * CHUNK;
        localparam int REM = WIDTH - LO;
        localparam int IW  = REM + CHUNK;

        logic           v_q, v_d;
        logic           cy_q, cy_d;
        logic [LO-1:0]  sum_q, sum_d, sum_new;
        logic [IW-1:0]  a_in, b_in;
        logic           up_v, cin;
        logic           nxt_en, en, take;
        logic [CHUNK:0] add;

        if (k == 0) begin : g_src
            assign up_v    = bus.in_valid;
            assign a_in    = bus.a;
            assign b_in    = bus.b;
            assign cin     = bus.c_in;
            assign sum_new = add[CHUNK-1:0];
        end else begin : g_src
            assign up_v    = g_st[k-1].v_q;
            assign a_in    = g_st[k-1].g_rem.a_rem_q;
            assign b_in    = g_st[k-1].g_rem.b_rem_q;
            assign cin     = g_st[k-1].cy_q;
            assign sum_new = {add[CHUNK-1:0],
                              g_st[k-1].sum_q};
        end

        if (k == STAGES - 1) begin : g_nxt
            assign nxt_en = bus.out_ready;
        end else begin : g_nxt
            assign nxt_en = g_st[k+1].en;
        end

        // An empty stage always advances, so bubbles collapse
        assign en   = !v_q || nxt_en;
        assign take = en && up_v;
        assign add  = {1'b0, a_in[CHUNK-1:0]}
                    + {1'b0, b_in[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, cin};

        always_comb begin
            v_d   = v_q;
            cy_d  = cy_q;
            sum_d = sum_q;
            if (en) begin
                v_d = up_v;
            end
            if (take) begin
                cy_d  = add[CHUNK];
                sum_d = sum_new;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else begin
                v_q   <= v_d;
                cy_q  <= cy_d;
                sum_q <= sum_d;
            end
        end

        if (REM > 0) begin : g_rem
            logic [REM-1:0] a_rem_q, a_rem_d;
            logic [REM-1:0] b_rem_q, b_rem_d;

            always_comb begin
                a_rem_d = a_rem_q;
                b_rem_d = b_rem_q;
                if (take) begin
                    a_rem_d = a_in[IW-1:CHUNK];
                    b_rem_d = b_in[IW-1:CHUNK];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else begin
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q, ovf_d, c_msb;

            // Carry into the MSB recovered from its sum bit
            assign c_msb = add[CHUNK-1]
                         ^ a_in[CHUNK-1]
                         ^ b_in[CHUNK-1];

            always_comb begin
                ovf_d = ovf_q;
                if (take) begin
                    ovf_d = c_msb ^ add[CHUNK];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign bus.in_ready  = rst_n && g_st[0].en;
    assign bus.out_valid = g_st[STAGES-1].v_q;
    assign bus.sum       = g_st[STAGES-1].sum_q;
    assign bus.c_out     = g_st[STAGES-1].cy_q;
    assign bus.ovf       = g_st[STAGES-1].g_ovf.ovf_q;
endmodule
